// File: rtl/fp32_pkg.sv
// Shared binary32 divider constants and FSM encoding.
package fp32_pkg;

    localparam int BIAS       = 127;
    localparam int ITERATIONS = 26;
    localparam int EXP_W      = 10;
    localparam int CNT_W      = 5;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORMALIZE,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/mant_div_iter.sv
// Radix-2 restoring mantissa divider: one quotient bit per clock, ITERATIONS bits per load.
module mant_div_iter
    import fp32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [23:0]           dividend,
    input  logic [23:0]           divisor,
    output logic [ITERATIONS-1:0] quotient,
    output logic                  rem_nonzero,
    output logic                  done
);

    logic [24:0]      rem;
    logic [23:0]      div_q;
    logic [CNT_W-1:0] count;
    logic             take;
    logic [23:0]      rem_sub;

    // Partial remainder stays below the divisor after each step, so 24 bits hold the difference.
    always_comb begin
        take    = (rem >= {1'b0, div_q});
        rem_sub = take ? 24'(rem - {1'b0, div_q}) : rem[23:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem      <= '0;
            div_q    <= '0;
            quotient <= '0;
            count    <= '0;
        end else if (load) begin
            rem      <= {1'b0, dividend};
            div_q    <= divisor;
            quotient <= '0;
            count    <= CNT_W'(ITERATIONS);
        end else if (count != '0) begin
            quotient <= {quotient[ITERATIONS-2:0], take};
            rem      <= {rem_sub, 1'b0};
            count    <= count - CNT_W'(1);
        end
    end

    assign rem_nonzero = (rem != '0);
    assign done        = (count == '0);

endmodule

// File: rtl/divider.sv
// IEEE-754 binary32 divider with fixed latency; denormal inputs flush to zero and
// results never go denormal. Round to nearest, ties to even.
module divider
    import fp32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividened,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] out_reg
);

    state_t state, next_state;

    logic [31:0]             a_reg, b_reg;
    logic                    sign_reg, special_reg;
    logic [31:0]             special_val;
    logic signed [EXP_W-1:0] exp_reg, norm_exp;
    logic [23:0]             norm_mant;
    logic                    norm_guard, norm_sticky;

    logic                    capture, iter_load, iter_done, rem_nonzero;
    logic [ITERATIONS-1:0]   quotient;

    logic [7:0]              exp_a, exp_b;
    logic [22:0]             frac_a, frac_b;
    logic                    a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic                    sign_c, special_c;
    logic [31:0]             special_val_c;
    logic signed [EXP_W-1:0] exp_c;

    logic [23:0]             norm_mant_c;
    logic                    norm_guard_c, norm_sticky_c;
    logic signed [EXP_W-1:0] norm_exp_c;

    logic                    round_up;
    logic [24:0]             rounded;
    logic signed [EXP_W-1:0] round_exp;
    logic [22:0]             round_frac;
    logic [31:0]             result_c;

    mant_div_iter u_iter (
        .clk        (clk),
        .rst        (rst),
        .load       (iter_load),
        .dividend   ({1'b1, frac_a}),
        .divisor    ({1'b1, frac_b}),
        .quotient   (quotient),
        .rem_nonzero(rem_nonzero),
        .done       (iter_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // DONE counts as not busy so a new request can be taken in the valid cycle.
    always_comb begin
        next_state = state;
        busy       = (state != IDLE) && (state != DONE);
        valid      = (state == DONE);
        capture    = start && !busy;
        iter_load  = (state == UNPACK);
        case (state)
            IDLE:      if (capture) next_state = UNPACK;
            UNPACK:    next_state = DIVIDE;
            DIVIDE:    if (iter_done) next_state = NORMALIZE;
            NORMALIZE: next_state = ROUND;
            ROUND:     next_state = DONE;
            DONE:      next_state = capture ? UNPACK : IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Special operands still run through the iterator so the latency never changes.
    always_comb begin
        exp_a  = a_reg[30:23];
        exp_b  = b_reg[30:23];
        frac_a = a_reg[22:0];
        frac_b = b_reg[22:0];
        a_zero = (exp_a == 8'h00);
        b_zero = (exp_b == 8'h00);
        a_inf  = (exp_a == 8'hFF) && (frac_a == '0);
        b_inf  = (exp_b == 8'hFF) && (frac_b == '0);
        a_nan  = (exp_a == 8'hFF) && (frac_a != '0);
        b_nan  = (exp_b == 8'hFF) && (frac_b != '0);
        sign_c = a_reg[31] ^ b_reg[31];
        exp_c  = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + EXP_W'(BIAS);

        special_c     = 1'b1;
        special_val_c = CANON_NAN;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
            special_val_c = CANON_NAN;
        else if (a_inf || b_zero)
            special_val_c = {sign_c, 8'hFF, 23'd0};
        else if (a_zero || b_inf)
            special_val_c = {sign_c, 31'd0};
        else
            special_c = 1'b0;
    end

    always_comb begin
        if (quotient[ITERATIONS-1]) begin
            norm_mant_c   = quotient[25:2];
            norm_guard_c  = quotient[1];
            norm_sticky_c = quotient[0] || rem_nonzero;
            norm_exp_c    = exp_reg;
        end else begin
            norm_mant_c   = quotient[24:1];
            norm_guard_c  = quotient[0];
            norm_sticky_c = rem_nonzero;
            norm_exp_c    = exp_reg - 10'sd1;
        end
    end

    // A rounding carry leaves the fraction all zeros, so rounded[23:1] is the right slice.
    always_comb begin
        round_up   = norm_guard && (norm_sticky || norm_mant[0]);
        rounded    = {1'b0, norm_mant} + {24'd0, round_up};
        round_exp  = rounded[24] ? norm_exp + 10'sd1 : norm_exp;
        round_frac = rounded[24] ? rounded[23:1] : rounded[22:0];
        if (special_reg)
            result_c = special_val;
        else if (round_exp >= 10'sd255)
            result_c = {sign_reg, 8'hFF, 23'd0};
        else if (round_exp <= 10'sd0)
            result_c = {sign_reg, 31'd0};
        else
            result_c = {sign_reg, round_exp[7:0], round_frac};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            sign_reg    <= 1'b0;
            special_reg <= 1'b0;
            special_val <= '0;
            exp_reg     <= '0;
            norm_mant   <= '0;
            norm_guard  <= 1'b0;
            norm_sticky <= 1'b0;
            norm_exp    <= '0;
            out_reg     <= '0;
        end else begin
            if (capture) begin
                a_reg <= dividened;
                b_reg <= divisor;
            end
            if (state == UNPACK) begin
                sign_reg    <= sign_c;
                exp_reg     <= exp_c;
                special_reg <= special_c;
                special_val <= special_val_c;
            end
            if (state == NORMALIZE) begin
                norm_mant   <= norm_mant_c;
                norm_guard  <= norm_guard_c;
                norm_sticky <= norm_sticky_c;
                norm_exp    <= norm_exp_c;
            end
            // Loaded on the edge into DONE so the quotient is present for the whole valid cycle.
            if (state == ROUND) out_reg <= result_c;
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed IEEE cases plus randomized operands
// scored against an integer long-division model of binary32 division.
module tb_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividened;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] out_reg;

    int          tests_run;
    int          tests_failed;
    int          edge_cnt;
    logic [31:0] last_result;
    logic [31:0] exp_q[$];
    int          due_q[$];

    localparam int LATENCY = 30;

    divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividened(dividened),
        .divisor  (divisor),
        .busy     (busy),
        .valid    (valid),
        .out_reg  (out_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Exact quotient from a wide integer division, then round-to-nearest-even on the top 24 bits.
    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [63:0] num, den, q, r;
        logic [23:0] m;
        logic        g, s;
        int          e;
        sign   = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 8'hFF) && (fa == 0);
        b_inf  = (eb == 8'hFF) && (fb == 0);
        a_nan  = (ea == 8'hFF) && (fa != 0);
        b_nan  = (eb == 8'hFF) && (fb != 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC00000;
        if (a_inf || b_zero) return {sign, 8'hFF, 23'd0};
        if (a_zero || b_inf) return {sign, 31'd0};
        num = {40'd0, 1'b1, fa} << 30;
        den = {40'd0, 1'b1, fb};
        q   = num / den;
        r   = num % den;
        e   = int'(ea) - int'(eb) + 127;
        if (q[30]) begin
            m = q[30:7];
            g = q[6];
            s = (q[5:0] != 0) || (r != 0);
        end else begin
            m = q[29:6];
            g = q[5];
            s = (q[4:0] != 0) || (r != 0);
            e = e - 1;
        end
        if (g && (s || m[0])) begin
            if (m == 24'hFFFFFF) begin
                m = 24'h800000;
                e = e + 1;
            end else begin
                m = m + 24'd1;
            end
        end
        if (e >= 255) return {sign, 8'hFF, 23'd0};
        if (e <= 0) return {sign, 31'd0};
        return {sign, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 11))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[30:0]  = 31'd0;
            3: v[30:23] = 8'($urandom_range(1, 24));
            4: v[30:23] = 8'($urandom_range(230, 254));
            5: begin
                v[30:23] = 8'($urandom_range(110, 144));
                v[11:0]  = 12'd0;
            end
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Compare process: the model says which cycle must carry valid and what out_reg must show.
    initial begin : compare
        logic exp_valid, exp_busy;
        last_result = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check_output("reset_busy", {31'd0, busy}, 32'd0);
                check_output("reset_valid", {31'd0, valid}, 32'd0);
                check_output("reset_out_reg", out_reg, 32'd0);
                exp_q.delete();
                due_q.delete();
                last_result = '0;
            end else begin
                exp_valid = (exp_q.size() != 0) && (edge_cnt == due_q[0]);
                exp_busy  = (exp_q.size() != 0) && !exp_valid;
                check_output("valid", {31'd0, valid}, {31'd0, exp_valid});
                check_output("busy", {31'd0, busy}, {31'd0, exp_busy});
                if (exp_valid) begin
                    check_output("quotient", out_reg, exp_q[0]);
                    last_result = exp_q[0];
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end else begin
                    check_output("out_reg_hold", out_reg, last_result);
                end
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        dividened = a;
        divisor   = b;
        @(posedge clk);
        #1;
        exp_q.push_back(model_div(a, b));
        due_q.push_back(edge_cnt + LATENCY);
        @(negedge clk);
        start     = 1'b0;
        dividened = $urandom;
        divisor   = $urandom;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        if (!seen) check_output("valid_wait_timeout", {31'd0, valid}, 32'd1);
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
        launch(a, b);
        wait_valid();
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expected);
        check_output({"model_", name}, model_div(a, b), expected);
        apply_stimulus(a, b);
        check_output(name, out_reg, expected);
    endtask

    initial begin : driver
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        start        = 1'b0;
        dividened    = '0;
        divisor      = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);

        directed("six_div_two",    32'h40C00000, 32'h40000000, 32'h40400000);
        directed("one_div_three",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
        directed("neg8_div_half",  32'hC1000000, 32'h3F000000, 32'hC1800000);
        directed("one_div_zero",   32'h3F800000, 32'h00000000, 32'h7F800000);
        directed("zero_div_zero",  32'h00000000, 32'h00000000, 32'h7FC00000);
        directed("overflow",       32'h7F000000, 32'h3E800000, 32'h7F800000);
        directed("underflow",      32'h00800000, 32'h7F000000, 32'h00000000);
        directed("neg_div_zero",   32'hBF800000, 32'h00000000, 32'hFF800000);
        directed("denorm_num",     32'h00400000, 32'h3F800000, 32'h00000000);
        directed("denorm_den",     32'h3F800000, 32'h00000001, 32'h7F800000);
        directed("inf_div_inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000);
        directed("nan_operand",    32'h7F800001, 32'h3F800000, 32'h7FC00000);
        directed("one_div_neginf", 32'h3F800000, 32'hFF800000, 32'h80000000);
        directed("neginf_div_two", 32'hFF800000, 32'h40000000, 32'hFF800000);

        // A second start while busy must be dropped.
        launch(32'h40C00000, 32'h40000000);
        repeat (5) @(negedge clk);
        start     = 1'b1;
        dividened = 32'h3F800000;
        divisor   = 32'h40400000;
        @(negedge clk);
        start = 1'b0;
        wait_valid();
        check_output("busy_ignore", out_reg, 32'h40400000);

        // Asynchronous reset mid-division, then a quiet window with no valid.
        launch(32'h3F800000, 32'h40400000);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (45) @(negedge clk);

        // Start on the first edge after reset release.
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        launch(32'hC1000000, 32'h3F000000);
        wait_valid();
        check_output("start_after_reset", out_reg, 32'hC1800000);

        for (int i = 0; i < 1200; i++) begin
            apply_stimulus(rand_fp(), rand_fp());
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
